// File: rtl/aes_reg_drain_status.sv
// Read-side drain tracker for multi-word output data registers (e.g. AES data_out).
// Optional saturating stall-cycle counter: define AES_DRAIN_STALL_CNT_EN.
module aes_reg_drain_status #(
    parameter int unsigned Width    = 4,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    re_i,
    input  logic                out_valid_i,
    output logic                out_ready_o,
    input  logic                manual_i,
    input  logic                clear_i,
    output logic                valid_o,
    output logic [Width-1:0]    read_mask_o,
    output logic                drained_pulse_o,
    output logic                overwrite_pulse_o,
    output logic                stall_o,
    output logic [CntWidth-1:0] stall_cnt_o
);

    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StFull    = 2'd1;
    localparam logic [1:0] StPartial = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [Width-1:0] mask_q, mask_d;
    logic [Width-1:0] mask_next;
    logic             held;
    logic             all_read;
    logic             handshake;

    // Acceptance, pulses and next state; ready is combinational for zero-latency refill
    always_comb begin
        held              = (state_q != StEmpty);
        mask_next         = held ? (mask_q | re_i) : mask_q;
        all_read          = held & (&mask_next);
        out_ready_o       = ~clear_i & (~held | all_read | manual_i);
        handshake         = out_valid_i & out_ready_o;
        drained_pulse_o   = all_read & ~clear_i;
        overwrite_pulse_o = handshake & held & ~all_read;
        stall_o           = out_valid_i & ~out_ready_o;

        state_d = state_q;
        mask_d  = mask_q;
        if (clear_i) begin
            state_d = StEmpty;
            mask_d  = '0;
        end else if (handshake) begin
            // Same-cycle reads belonged to the old block and are discarded
            state_d = StFull;
            mask_d  = '0;
        end else if (all_read) begin
            state_d = StEmpty;
            mask_d  = '0;
        end else if (held && (mask_next != '0)) begin
            state_d = StPartial;
            mask_d  = mask_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    assign valid_o     = held;
    assign read_mask_o = mask_q;

`ifdef AES_DRAIN_STALL_CNT_EN
    logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles; only clear_i resets it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear_i) begin
            stall_cnt_d = '0;
        end else if (stall_o && (stall_cnt_q != {CntWidth{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aes_reg_drain_status.sv
// Scoreboard bench for aes_reg_drain_status: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares. Honours AES_DRAIN_STALL_CNT_EN like the design.
module tb_aes_reg_drain_status;

    localparam int unsigned W      = 4;
    localparam int unsigned CW     = 4;
    localparam int          CntMax = (1 << CW) - 1;

    typedef struct packed {
        logic          ready;
        logic          drained;
        logic          overwrite;
        logic          stall;
        logic          valid;
        logic [W-1:0]  mask;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [W-1:0]  re_i = '0;
    logic          out_valid_i = 1'b0;
    logic          out_ready_o;
    logic          manual_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          valid_o;
    logic [W-1:0]  read_mask_o;
    logic          drained_pulse_o;
    logic          overwrite_pulse_o;
    logic          stall_o;
    logic [CW-1:0] stall_cnt_o;

    aes_reg_drain_status #(.Width(W), .CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .re_i(re_i), .out_valid_i(out_valid_i),
        .out_ready_o(out_ready_o), .manual_i(manual_i), .clear_i(clear_i),
        .valid_o(valid_o), .read_mask_o(read_mask_o),
        .drained_pulse_o(drained_pulse_o), .overwrite_pulse_o(overwrite_pulse_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: a held flag, one "already read" flag per word, a stall tally
    bit   m_held = 1'b0;
    bit   m_rd[W];
    int   m_cnt = 0;
    bit   in_rst = 1'b0;

    task automatic model_reset();
        m_held = 1'b0;
        for (int i = 0; i < W; i++) m_rd[i] = 1'b0;
        m_cnt = 0;
    endtask

    task automatic chk(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, want);
        end
    endtask

    always @(negedge clk_i) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_ready", int'(out_ready_o), int'(e.ready));
            chk("drained", int'(drained_pulse_o), int'(e.drained));
            chk("overwrite", int'(overwrite_pulse_o), int'(e.overwrite));
            chk("stall", int'(stall_o), int'(e.stall));
            chk("valid", int'(valid_o), int'(e.valid));
            chk("read_mask", int'(read_mask_o), int'(e.mask));
            chk("stall_cnt", int'(stall_cnt_o), int'(e.cnt));
        end
    end

    // Called at posedge+1: drive inputs, predict this cycle, advance model, wait an edge
    task automatic cycle(input logic [W-1:0] re, input logic ov, input logic man,
                         input logic clr);
        exp_t e;
        bit   all_read;
        bit   hs;
        re_i = re; out_valid_i = ov; manual_i = man; clear_i = clr;
        all_read = m_held;
        for (int i = 0; i < W; i++) if (!m_rd[i] && !re[i]) all_read = 1'b0;
        e.ready     = !clr && (!m_held || all_read || man);
        hs          = ov && e.ready;
        e.drained   = all_read && !clr;
        e.overwrite = hs && m_held && !all_read;
        e.stall     = ov && !e.ready;
        e.valid     = m_held;
        for (int i = 0; i < W; i++) e.mask[i] = m_rd[i];
`ifdef AES_DRAIN_STALL_CNT_EN
        e.cnt = CW'(m_cnt);
`else
        e.cnt = '0;
`endif
        exp_q.push_back(e);
        if (!in_rst) begin
            if (clr) begin
                model_reset();
            end else begin
                if (e.stall && m_cnt < CntMax) m_cnt++;
                if (hs) begin
                    m_held = 1'b1;
                    for (int i = 0; i < W; i++) m_rd[i] = 1'b0;
                end else if (all_read) begin
                    m_held = 1'b0;
                    for (int i = 0; i < W; i++) m_rd[i] = 1'b0;
                end else if (m_held) begin
                    for (int i = 0; i < W; i++) if (re[i]) m_rd[i] = 1'b1;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [W-1:0] r;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        cycle('0, 1'b0, 1'b0, 1'b0);          // checks reset values while still in reset
        rst_ni = 1'b1;
        in_rst = 1'b0;

        // Load, split read with refill on final read
        cycle('0, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0011, 1'b1, 1'b0, 1'b0);
        cycle(4'b1100, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        // Manual overwrite of a loaded block
        cycle(4'b0001, 1'b1, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        // PARTIAL 0101 then clear with a pending block
        cycle(4'b0101, 1'b0, 1'b0, 1'b0);
        cycle('0, 1'b1, 1'b0, 1'b1);
        cycle('0, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        // Duplicate read, then drain, then reads while empty
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(4'b1110, 1'b0, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(4'b0110, 1'b0, 1'b0, 1'b0);
        // Long stall for counter saturation, then clear
        cycle('0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle('0, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with a mid-run asynchronous reset
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                rst_ni = 1'b0;
                in_rst = 1'b1;
                model_reset();
                cycle('0, 1'b1, 1'b0, 1'b0);
                cycle('0, 1'b1, 1'b0, 1'b0);
                rst_ni = 1'b1;
                in_rst = 1'b0;
            end
            for (int i = 0; i < W; i++) r[i] = ($urandom_range(0, 9) < 3);
            cycle(r, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 49) == 0));
        end

        re_i = '0; out_valid_i = 1'b0; manual_i = 1'b0; clear_i = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_i);
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain_queue left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
